// File: rtl/count_connected_feeder.sv
// Feeder and flow controller for one streaming connected-count core: bubble/freeze sequencing,
// 4-deep result skid FIFO, in-flight tracking, flush handshake. Perf counters: FEEDER_PERF_COUNTERS_EN.
module count_connected_feeder #(
  parameter int EXTRA_DATA_WIDTH = 1,
  parameter int MAX_IN_FLIGHT    = 500
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        inValid,
  output logic                        inReady,
  input  logic [127:0]                inGraph,
  input  logic [EXTRA_DATA_WIDTH-1:0] inExtra,
  input  logic                        flushRequest,
  output logic                        flushDone,
  output logic                        coreBotValid,
  output logic [127:0]                coreGraph,
  output logic [EXTRA_DATA_WIDTH-1:0] coreExtra,
  output logic                        coreFreeze,
  input  logic                        coreAlmostFull,
  input  logic                        coreResultValid,
  input  logic [5:0]                  coreConnectCount,
  input  logic [EXTRA_DATA_WIDTH-1:0] coreExtraOut,
  input  logic                        coreEcc,
  output logic                        outValid,
  input  logic                        outReady,
  output logic [5:0]                  outConnectCount,
  output logic [EXTRA_DATA_WIDTH-1:0] outExtra,
  output logic [9:0]                  inFlight,
  output logic                        eccError,
  output logic                        underflowError,
  output logic [31:0]                 frozenCycles,
  output logic [31:0]                 bubbleCycles
);

  typedef enum logic [1:0] {RUN = 2'd0, FLUSH = 2'd1, DONE = 2'd2} feederState_t;

  localparam logic [9:0] MaxInFlight = MAX_IN_FLIGHT[9:0];

  feederState_t                state, stateNext;
  logic [2:0]                  skidCount;
  logic [1:0]                  wrPtr, rdPtr;
  logic [5:0]                  skidCnt [4];
  logic [EXTRA_DATA_WIDTH-1:0] skidExt [4];
  logic                        freezeNext, accept, push, pop;

  // The core can still emit two results after freeze rises, so freeze once a second entry is imminent.
  assign freezeNext = (({1'b0, skidCount} + {3'b000, coreResultValid}) >= 4'd2)
                    || ((skidCount != 3'd0) && !outReady);
  assign inReady    = !rst && (state == RUN) && !freezeNext && !coreAlmostFull
                    && (inFlight < MaxInFlight);
  assign accept     = inValid && inReady;

  assign outValid        = (skidCount != 3'd0);
  assign pop             = outValid && outReady;
  assign push            = coreResultValid && ((skidCount != 3'd4) || pop);
  assign outConnectCount = skidCnt[rdPtr];
  assign outExtra        = skidExt[rdPtr];
  assign flushDone       = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      coreBotValid <= 1'b0;
      coreGraph    <= '0;
      coreExtra    <= '0;
      coreFreeze   <= 1'b0;
    end else begin
      coreBotValid <= accept;
      coreFreeze   <= freezeNext;
      if (accept) begin
        coreGraph <= inGraph;
        coreExtra <= inExtra;
      end
    end
  end

  // Results land in the skid FIFO regardless of freeze; no same-cycle bypass to the output.
  always_ff @(posedge clk) begin
    if (rst) begin
      skidCount <= '0;
      wrPtr     <= '0;
      rdPtr     <= '0;
      for (int i = 0; i < 4; i++) begin
        skidCnt[i] <= '0;
        skidExt[i] <= '0;
      end
    end else begin
      if (push) begin
        skidCnt[wrPtr] <= coreConnectCount;
        skidExt[wrPtr] <= coreExtraOut;
        wrPtr          <= wrPtr + 2'd1;
      end
      if (pop) begin
        rdPtr <= rdPtr + 2'd1;
      end
      case ({push, pop})
        2'b10:   skidCount <= skidCount + 3'd1;
        2'b01:   skidCount <= skidCount - 3'd1;
        default: skidCount <= skidCount;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inFlight       <= '0;
      eccError       <= 1'b0;
      underflowError <= 1'b0;
    end else begin
      case ({accept, coreResultValid})
        2'b10:   inFlight <= inFlight + 10'd1;
        2'b01:   inFlight <= (inFlight != 10'd0) ? inFlight - 10'd1 : 10'd0;
        default: inFlight <= inFlight;
      endcase
      if (coreResultValid && (inFlight == 10'd0)) begin
        underflowError <= 1'b1;
      end
      if (coreEcc) begin
        eccError <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    case (state)
      RUN:     if (flushRequest) stateNext = FLUSH;
      FLUSH:   if ((inFlight == 10'd0) && (skidCount == 3'd0)) stateNext = DONE;
      DONE:    stateNext = RUN;
      default: stateNext = RUN;
    endcase
  end

`ifdef FEEDER_PERF_COUNTERS_EN
  // Both counters saturate rather than wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      frozenCycles <= '0;
      bubbleCycles <= '0;
    end else begin
      if (coreFreeze && (frozenCycles != 32'hFFFF_FFFF)) begin
        frozenCycles <= frozenCycles + 32'd1;
      end
      if (!coreFreeze && !coreBotValid && (bubbleCycles != 32'hFFFF_FFFF)) begin
        bubbleCycles <= bubbleCycles + 32'd1;
      end
    end
  end
`else
  assign frozenCycles = '0;
  assign bubbleCycles = '0;
`endif

endmodule

// File: doc/count_connected_feeder.md
# count_connected_feeder

Single-core feeder and flow controller for one streaming connected-count core. It owns the core's `freezeCore`/`isBotValid` sequencing:
- accepts bot graphs from an upstream valid/ready stream;
- inserts bubbles while the core input FIFO is almost full;
- freezes the core when downstream applies backpressure;
- buffers results in a 4-deep skid FIFO, tracks in-flight bots, and provides a flush/drain handshake for batch boundaries.

## Interface

Parameters:
- `EXTRA_DATA_WIDTH`, default 1: width of sideband data carried alongside each bot.
- `MAX_IN_FLIGHT`, default 500: in-flight bot limit. Must be below 512, the core slot ring size.

Ports:
- `clk` input 1: single clock. All logic is in this domain.
- `rst` input 1: synchronous, active-high reset.
- `inValid` input 1: upstream bot valid.
- `inReady` output 1: upstream ready (combinational).
- `inGraph` input 128: bot graph.
- `inExtra` input `EXTRA_DATA_WIDTH`: bot sideband data.
- `flushRequest` input 1: single-cycle pulse that starts a drain.
- `flushDone` output 1: single-cycle pulse when the drain is complete.
- `coreBotValid` output 1: to the core's `isBotValid`, registered.
- `coreGraph` output 128: to the core's `graphIn`, registered.
- `coreExtra` output `EXTRA_DATA_WIDTH`: to the core's `extraDataIn`, registered.
- `coreFreeze` output 1: to the core's `freezeCore`, registered.
- `coreAlmostFull` input 1: from the core.
- `coreResultValid` input 1: core result valid.
- `coreConnectCount` input 6: core result count.
- `coreExtraOut` input `EXTRA_DATA_WIDTH`: core result sideband data.
- `coreEcc` input 1: core `eccStatus`.
- `outValid` output 1: downstream result valid.
- `outReady` input 1: downstream ready.
- `outConnectCount` output 6: result count to downstream.
- `outExtra` output `EXTRA_DATA_WIDTH`: result sideband data to downstream.
- `inFlight` output 10: bots accepted but whose results have not yet been captured.
- `eccError` output 1: sticky; set by `coreEcc`.
- `underflowError` output 1: sticky; set by a result arriving with `inFlight==0`.
- `frozenCycles` output 32: performance counter (see Configuration).
- `bubbleCycles` output 32: performance counter (see Configuration).

## Operation

**State machine (2-bit): RUN, FLUSH, DONE.**
- Reset state is RUN.
- RUN -> FLUSH on `flushRequest`.
- FLUSH -> DONE when `inFlight==0` and the skid FIFO is empty.
- DONE -> RUN unconditionally after 1 cycle. `flushDone`=1 only in DONE.
- `flushRequest` outside RUN is ignored.

**Freeze and accept.**
- `freezeNext = (skidCount + incoming >= 2) || (skidCount>=1 && !outReady)`, where `incoming = coreResultValid`.
- `coreFreeze <= freezeNext`.
- `inReady = (state==RUN) && !freezeNext && !coreAlmostFull && inFlight < MAX_IN_FLIGHT`.
- Accept = `inValid && inReady`. On the next edge: `coreBotValid<=1`, `coreGraph<=inGraph`, `coreExtra<=inExtra`.
- Otherwise `coreBotValid<=0`, while graph and extra hold their values.
- Invariant: `coreBotValid && coreFreeze` is never 1 in the same cycle.

**Skid FIFO (4 entries: count + extra).**
- Written on every `coreResultValid`, independent of freeze. The core may emit up to 2 results after `coreFreeze` rises, so depth 4 never overflows.
- `outValid` = not empty. Pop on `outValid && outReady`.
- Simultaneous push and pop on an empty FIFO is not a bypass: the entry appears on the next cycle.

**In-flight counter.**
- Accept and capture in the same cycle: `inFlight` holds.
- Accept only: +1. Capture only: -1.
- Capture with `inFlight==0`: counter stays 0 and `underflowError` sets.

**Errors and reset.**
- `eccError` sets on `coreEcc==1`, clears only on `rst`.
- `rst` mid-operation discards skid contents and in-flight accounting immediately; no `flushDone` is produced.

## Timing

- Reset values:
  - `inReady`=0 while `rst`=1.
  - `coreBotValid`=0, `coreFreeze`=0, `coreGraph`=0, `coreExtra`=0.
  - `outValid`=0, `outConnectCount`=0, `outExtra`=0.
  - `flushDone`=0, `inFlight`=0, `eccError`=0, `underflowError`=0, `frozenCycles`=0, `bubbleCycles`=0.
- Input-to-core latency: 1 cycle.
- `outValid` rises 1 cycle after a capture into an empty skid FIFO.
- `coreFreeze` deasserts 1 cycle after the condition clears. No minimum freeze length.
- `flushDone` pulses exactly 1 cycle after the drain condition is met in FLUSH.

## Configuration

`FEEDER_PERF_COUNTERS_EN`:
- Defined:
  - `frozenCycles` increments on every cycle with `coreFreeze`=1.
  - `bubbleCycles` increments on every cycle with `coreFreeze`=0 and `coreBotValid`=0.
  - Both saturate at 2^32-1.
- Undefined: both outputs are tied to 0 and no counter registers are synthesized.

## Test plan

- Stream 10 bots with `outReady`=1; the core model returns results 512 cycles later -> 10 in-order results on `out*`, `inFlight` peaks at 10 and returns to 0, no errors.
- Hold `coreAlmostFull`=1 for 20 cycles mid-stream -> `inReady`=0 and `coreBotValid`=0 for those cycles; with `FEEDER_PERF_COUNTERS_EN`, `bubbleCycles` grows by ≥20.
- Drop `outReady` while results are arriving -> `coreFreeze`=1 within 1 cycle, skid never exceeds 4, and after `outReady`=1 all results are delivered without loss or duplication.
- `flushRequest` with 3 bots in flight -> `inReady`=0 until `flushDone`; `flushDone` pulses once, 1 cycle after the 3rd result drains; state returns to RUN.
- Accept and result capture in the same cycle at `inFlight`=5 -> stays 5. A `coreResultValid` at `inFlight`=0 -> `underflowError`=1, held until `rst`.
- Assert `rst` for 1 cycle with the skid FIFO holding 2 entries -> next cycle `outValid`=0, `inFlight`=0, `coreFreeze`=0, and no `flushDone`.
